// File: rtl/lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: funct3 sizes, FSM states,
// fault codes and the access legality check used at issue time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // Illegal encodings take precedence; alignment is only meaningful for a known size.
    function automatic logic [1:0] check_access(input logic [2:0] f3,
                                                input logic       is_store,
                                                input logic [1:0] lo);
        logic [1:0] code;
        code = FAULT_NONE;
        case (f3)
            F3_B:  code = FAULT_NONE;
            F3_BU: code = is_store ? FAULT_ILLEGAL : FAULT_NONE;
            F3_H:  code = lo[0] ? FAULT_MISALIGN : FAULT_NONE;
            F3_HU: code = is_store ? FAULT_ILLEGAL : (lo[0] ? FAULT_MISALIGN : FAULT_NONE);
            F3_W:  code = (lo != 2'b00) ? FAULT_MISALIGN : FAULT_NONE;
            default: code = FAULT_ILLEGAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed byte/halfword out of a returned memory word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_data = {24'h0, byte_sel};
            F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_data = {16'h0, half_sel};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: issues one word-addressed access per instruction,
// stalls the pipeline until memory answers, and reports access faults.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  funct3_p1;
    logic [1:0]  offset_p1;
    logic [1:0]  chk;
    logic        req;
    logic        issue;
    logic        reject;
    logic        ready_hit;
    logic        timed_out;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] ext_data;

    assign req       = mem_read | mem_write;
    assign chk       = check_access(funct3, mem_write, addr[1:0]);
    assign issue     = (state == IDLE) && req && (chk == FAULT_NONE);
    assign reject    = (state == IDLE) && req && (chk != FAULT_NONE);
    assign ready_hit = (state == BUSY) && mem_ready;
    assign timed_out = (state == BUSY) && !mem_ready && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = BUSY;
            BUSY:    if (mem_ready || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DONE deliberately drops stall so the held instruction leaves MEM without re-issuing.
    always_comb begin
        mem_req = (state == BUSY);
        stall   = !rst && ((state == BUSY) || issue);
    end

    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            cnt <= '0;
        end else if (!mem_ready) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Stores are lane-steered; loads always fetch the whole word.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = '0;
        if (mem_write) begin
            case (funct3)
                F3_B: begin
                    be_nxt    = 4'b0001 << addr[1:0];
                    wdata_nxt = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be_nxt    = 4'b0011 << {addr[1], 1'b0};
                    wdata_nxt = {2{wdata[15:0]}};
                end
                default: wdata_nxt = wdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_p1 <= '0;
            offset_p1 <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            fault     <= FAULT_NONE;
            load_data <= '0;
        end else begin
            fault <= FAULT_NONE;
            if (issue) begin
                funct3_p1 <= funct3;
                offset_p1 <= addr[1:0];
                mem_we    <= mem_write;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_nxt;
                mem_wdata <= wdata_nxt;
            end
            if (reject) begin
                fault     <= chk;
                load_data <= '0;
            end
            if (timed_out) begin
                fault     <= FAULT_TIMEOUT;
                load_data <= '0;
            end
            if (ready_hit && !mem_we) begin
                load_data <= ext_data;
            end
        end
    end

    lsu_load_extract u_extract (
        .funct3   (funct3_p1),
        .offset   (offset_p1),
        .rdata    (mem_rdata),
        .ext_data (ext_data)
    );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected load_data/fault pushed at issue,
// popped and compared when the access completes or is rejected.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] load_data;
    logic        stall;
    logic [1:0]  fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .load_data(load_data),
        .stall(stall), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic [31:0] ld;
        logic [1:0]  flt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ld_model = 32'h0;

    // Drives one request and plays the memory: ready on BUSY cycle ready_at (-1 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int ready_at,
                             output int stall_cnt, output int busy_cnt,
                             output logic done_stall, output logic [1:0] done_flt,
                             output logic [31:0] done_ld, output logic done_ok,
                             output logic [31:0] s_addr, output logic [31:0] s_wdata,
                             output logic [3:0] s_be, output logic s_we);
        stall_cnt = 0; busy_cnt = 0; done_ok = 1'b0; done_stall = 1'b1;
        done_flt = 2'b00; done_ld = 32'h0;
        s_addr = 32'h0; s_wdata = 32'h0; s_be = 4'h0; s_we = 1'b0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        if (stall) stall_cnt++;
        for (int i = 0; i < 40 && !done_ok; i++) begin
            @(negedge clk);
            if (mem_req) begin
                busy_cnt++;
                if (busy_cnt == 1) begin
                    s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be; s_we = mem_we;
                end
                if (stall) stall_cnt++;
                if (busy_cnt - 1 == ready_at) begin
                    mem_ready = 1'b1; mem_rdata = rdat;
                end else begin
                    mem_ready = 1'b0; mem_rdata = $urandom();
                end
            end else begin
                done_stall = stall; done_flt = fault; done_ld = load_data; done_ok = 1'b1;
                mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load_data: got %h want 0", load_data); end
        n_cmp++; if ({stall, mem_req, mem_we, fault} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got stall=%b req=%b we=%b fault=%b want all 0", stall, mem_req, mem_we, fault); end
        n_cmp++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin n_fail++; $display("FAIL reset_bus: got addr=%h be=%b wdata=%h want 0", mem_addr, mem_be, mem_wdata); end
        rst = 1'b0;
        ld_model = 32'h0;
    endtask

    task automatic test_store_byte();
        int sc, bc; logic ds, ok, we; logic [1:0] df; logic [31:0] dl, sa, sw; logic [3:0] be; exp_t e;
        sb.push_back('{ld: ld_model, flt: FAULT_NONE});
        do_access(1'b0, 1'b1, F3_B, 32'h1003, 32'h000000A5, 32'h0, 0, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sb_done: got %b want 1", ok); end
        n_cmp++; if (sa !== 32'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", sa); end
        n_cmp++; if (be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", be); end
        n_cmp++; if (sw !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", sw); end
        n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", we); end
        n_cmp++; if (sc !== 2) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d want 2", sc); end
        n_cmp++; if (ds !== 1'b0) begin n_fail++; $display("FAIL sb_done_stall: got %b want 0", ds); end
        e = sb.pop_front();
        n_cmp++; if (df !== e.flt || dl !== e.ld) begin n_fail++; $display("FAIL sb_result: got fault=%b ld=%h want fault=%b ld=%h", df, dl, e.flt, e.ld); end
    endtask

    task automatic test_load_extract();
        int sc, bc; logic ds, ok, we; logic [1:0] df; logic [31:0] dl, sa, sw; logic [3:0] be; exp_t e;
        logic [2:0]  f3s [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] rds [4] = '{32'h12F43456, 32'h12F43456, 32'h8001FFFF, 32'h8001FFFF};
        logic [31:0] exps[4] = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFF8001, 32'h00008001};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ld: exps[i], flt: FAULT_NONE});
            do_access(1'b1, 1'b0, f3s[i], 32'h2002, 32'hFFFFFFFF, rds[i], 0, sc, bc, ds, df, dl, ok, sa, sw, be, we);
            ld_model = exps[i];
            n_cmp++; if (ok !== 1'b1 || bc !== 1) begin n_fail++; $display("FAIL ld%0d_busy: got done=%b busy=%0d want 1/1", i, ok, bc); end
            n_cmp++; if (be !== 4'b1111 || we !== 1'b0 || sa !== 32'h2000) begin n_fail++; $display("FAIL ld%0d_bus: got be=%b we=%b addr=%h want 1111/0/00002000", i, be, we, sa); end
            e = sb.pop_front();
            n_cmp++; if (dl !== e.ld || df !== e.flt) begin n_fail++; $display("FAIL ld%0d_data: got ld=%h fault=%b want ld=%h fault=%b", i, dl, df, e.ld, e.flt); end
        end
        sb.push_back('{ld: 32'hDEADBEEF, flt: FAULT_NONE});
        do_access(1'b1, 1'b0, F3_W, 32'h2004, 32'h0, 32'hDEADBEEF, 2, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        ld_model = 32'hDEADBEEF;
        n_cmp++; if (bc !== 3 || sc !== 4) begin n_fail++; $display("FAIL lw_wait: got busy=%0d stall=%0d want 3/4", bc, sc); end
        e = sb.pop_front();
        n_cmp++; if (dl !== e.ld || df !== e.flt) begin n_fail++; $display("FAIL lw_data: got ld=%h fault=%b want ld=%h fault=%b", dl, df, e.ld, e.flt); end
    endtask

    task automatic test_timeout();
        int sc, bc; logic ds, ok, we; logic [1:0] df; logic [31:0] dl, sa, sw; logic [3:0] be; exp_t e;
        sb.push_back('{ld: 32'h0, flt: FAULT_TIMEOUT});
        do_access(1'b1, 1'b0, F3_W, 32'h2008, 32'h0, 32'h0, -1, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        ld_model = 32'h0;
        n_cmp++; if (ok !== 1'b1 || bc !== 4) begin n_fail++; $display("FAIL to_busy_cycles: got done=%b busy=%0d want 1/4", ok, bc); end
        e = sb.pop_front();
        n_cmp++; if (df !== e.flt || dl !== e.ld) begin n_fail++; $display("FAIL to_result: got fault=%b ld=%h want fault=%b ld=%h", df, dl, e.flt, e.ld); end
        @(negedge clk);
        n_cmp++; if ({fault, mem_req, stall} !== 4'b0) begin n_fail++; $display("FAIL to_idle: got fault=%b req=%b stall=%b want 0", fault, mem_req, stall); end
    endtask

    // Drives a rejected request and checks the one-cycle fault pulse.
    task automatic test_reject(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [1:0] code);
        exp_t e;
        sb.push_back('{ld: 32'h0, flt: code});
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'hCAFE1234;
        #1;
        n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rej%b_issue: got stall=%b req=%b want 0/0", code, stall, mem_req); end
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (fault !== e.flt || load_data !== e.ld || mem_req !== 1'b0) begin n_fail++; $display("FAIL rej%b_pulse: got fault=%b ld=%h req=%b want fault=%b ld=%h req=0", code, fault, load_data, mem_req, e.flt, e.ld); end
        mem_read = 1'b0; mem_write = 1'b0;
        ld_model = 32'h0;
        @(negedge clk);
        n_cmp++; if (fault !== FAULT_NONE) begin n_fail++; $display("FAIL rej%b_width: got fault=%b want 00", code, fault); end
    endtask

    task automatic test_reset_busy();
        int sc, bc; logic ds, ok, we; logic [1:0] df; logic [31:0] dl, sa, sw; logic [3:0] be;
        do_access(1'b1, 1'b0, F3_W, 32'h2010, 32'h0, 32'h11223344, 0, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        n_cmp++; if (dl !== 32'h11223344) begin n_fail++; $display("FAIL rb_preload: got %h want 11223344", dl); end
        @(negedge clk);
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h2014; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_second_busy: got req=%b want 1", mem_req); end
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++; if ({mem_req, fault, stall} !== 4'b0 || load_data !== 32'h0) begin n_fail++; $display("FAIL rb_after_rst: got req=%b fault=%b stall=%b ld=%h want 0", mem_req, fault, stall, load_data); end
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem_req, fault, stall} !== 4'b0 || load_data !== 32'h0) begin n_fail++; $display("FAIL rb_stray_ready: got req=%b fault=%b stall=%b ld=%h want 0", mem_req, fault, stall, load_data); end
        mem_ready = 1'b0;
        ld_model = 32'h0;
    endtask

    task automatic test_back_to_back();
        int sc, bc; logic ds, ok, we; logic [1:0] df; logic [31:0] dl, sa, sw; logic [3:0] be; exp_t e;
        sb.push_back('{ld: ld_model, flt: FAULT_NONE});
        do_access(1'b1, 1'b1, F3_W, 32'h40, 32'h01234567, 32'h99999999, 0, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        n_cmp++; if (we !== 1'b1 || be !== 4'b1111 || sw !== 32'h01234567 || sa !== 32'h40) begin n_fail++; $display("FAIL prio_bus: got we=%b be=%b wdata=%h addr=%h want 1/1111/01234567/00000040", we, be, sw, sa); end
        e = sb.pop_front();
        n_cmp++; if (dl !== e.ld || df !== e.flt) begin n_fail++; $display("FAIL prio_result: got ld=%h fault=%b want ld=%h fault=%b", dl, df, e.ld, e.flt); end
        sb.push_back('{ld: ld_model, flt: FAULT_NONE});
        do_access(1'b0, 1'b1, F3_H, 32'h42, 32'h1234BEEF, 32'h0, 0, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        n_cmp++; if (be !== 4'b1100 || sw !== 32'hBEEFBEEF || sa !== 32'h40) begin n_fail++; $display("FAIL sh_bus: got be=%b wdata=%h addr=%h want 1100/beefbeef/00000040", be, sw, sa); end
        e = sb.pop_front();
        n_cmp++; if (dl !== e.ld || df !== e.flt) begin n_fail++; $display("FAIL sh_result: got ld=%h fault=%b want ld=%h fault=%b", dl, df, e.ld, e.flt); end
        sb.push_back('{ld: 32'h55AA33CC, flt: FAULT_NONE});
        do_access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h55AA33CC, 1, sc, bc, ds, df, dl, ok, sa, sw, be, we);
        ld_model = 32'h55AA33CC;
        n_cmp++; if (bc !== 2 || sc !== 3) begin n_fail++; $display("FAIL b2b_lw_wait: got busy=%0d stall=%0d want 2/3", bc, sc); end
        e = sb.pop_front();
        n_cmp++; if (dl !== e.ld || df !== e.flt) begin n_fail++; $display("FAIL b2b_lw_data: got ld=%h fault=%b want ld=%h fault=%b", dl, df, e.ld, e.flt); end
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        test_reset();
        test_store_byte();
        test_load_extract();
        test_timeout();
        test_reject(1'b1, 1'b0, F3_W, 32'h3001, FAULT_MISALIGN);
        test_reject(1'b0, 1'b1, F3_H, 32'h3001, FAULT_MISALIGN);
        test_reject(1'b0, 1'b1, 3'b110, 32'h3000, FAULT_ILLEGAL);
        test_reject(1'b0, 1'b1, F3_BU, 32'h3000, FAULT_ILLEGAL);
        test_reset_busy();
        test_back_to_back();
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
